melody_sequencer: RTL and testbench
===================================

MELODY_SEQUENCER -- requirements
Module: melody_sequencer

Interface
REQ-001 Parameter SEQ_LEN, default 3: number of notes played per run; legal range 1..8.
REQ-002 Parameter D0..D7, default D0=3, D1=8, D2=6, D3..D7=10: note code per step; 0..9 = tone, 10 = silence.
REQ-003 Parameter NOTE_TICKS, default 12_500_000: clk cycles each note is held; legal range 1..2^26-1.
REQ-004 Parameter GAP_TICKS, default 2_500_000: clk cycles of silence after each note; legal range 0..2^26-1.
REQ-005 clk  input  1  system clock, 25 MHz; all state updates on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 sw_play  input  1  play switch, active-low, asynchronous to clk.
REQ-008 sw_stop  input  1  stop switch, active-low, asynchronous to clk.
REQ-009 note  output  4  registered note code for the downstream tone generator; 10 = silence.
REQ-010 busy  output  1  registered; high while a run is in progress (PLAY or GAP state).
REQ-011 step  output  3  registered index of the current note, 0..SEQ_LEN-1.

Function
REQ-012 Each switch SHALL pass through a 2-flop synchronizer, followed by one history flop for edge detection.
REQ-013 play_req SHALL be asserted for exactly one cycle when the synchronized sw_play is 0 and its history flop is 1; stop_req likewise for sw_stop.
REQ-014 A held switch SHALL NOT retrigger; a new request needs release (1) then press (0).
REQ-015 States SHALL be IDLE, PLAY, GAP; encoding is free.
REQ-016 IDLE: note=10, busy=0, step=0; play_req -> PLAY with step=0, note=D0, tick counter=0.
REQ-017 PLAY: note=D[step]; counter increments each cycle; on the cycle counter equals NOTE_TICKS-1: if GAP_TICKS>0 -> GAP with note=10 and counter=0, else the step-advance rule of REQ-019 applies directly.
REQ-018 GAP: note=10; counter increments; on the cycle counter equals GAP_TICKS-1 the step-advance rule applies.
REQ-019 Step advance: if step<SEQ_LEN-1 -> PLAY with step+1, note=D[step+1], counter=0; else -> IDLE with step=0, note=10, busy=0.
REQ-020 Each note SHALL be present on note for exactly NOTE_TICKS cycles and each gap SHALL last exactly GAP_TICKS cycles.
REQ-021 Latency: note SHALL show D0 after the 3rd rising clk edge following the sw_play falling edge, provided setup is met at the 1st edge.
REQ-022 play_req in PLAY or GAP SHALL be ignored; it never restarts the run.
REQ-023 stop_req in any state SHALL force IDLE at the next edge (note=10, busy=0, step=0, counter=0).
REQ-024 Simultaneous play_req and stop_req SHALL resolve as stop: the block stays in or returns to IDLE.
REQ-025 Tick counter SHALL be 26 bits and SHALL never wrap during a legal run.
REQ-026 Step SHALL never exceed SEQ_LEN-1.
REQ-027 busy SHALL be 1 in exactly the cycles where the state is PLAY or GAP.

Reset
REQ-028 While rst=1: state=IDLE, note=10, busy=0, step=0, counter=0, all synchronizer and history flops=1 (released).
REQ-029 rst asserted mid-run SHALL abort immediately, with no completion of the current note or gap.
REQ-030 After rst deasserts with sw_play already held at 0, no run SHALL start until sw_play is released and pressed again.

Verification (NOTE_TICKS=4, GAP_TICKS=2, SEQ_LEN=3, D0/D1/D2=3/8/6)
REQ-031 sw_play pulse low 10 cycles -> note sequence 3x4 cycles, 10x2, 8x4, 10x2, 6x4, 10x2, then IDLE; busy high 18 cycles; step 0,1,2.
REQ-032 GAP_TICKS=0, same pulse -> note 3,3,3,3,8,8,8,8,6,6,6,6 back-to-back, then 10; busy high 12 cycles.
REQ-033 Second sw_play press during the D1 note -> sequence unchanged; total busy still 18 cycles.
REQ-034 sw_stop pressed during the D1 note -> note=10, busy=0, step=0 one cycle after stop_req; a later sw_play restarts from D0.
REQ-035 sw_play and sw_stop fall on the same cycle in IDLE -> no run; note stays 10 and busy stays 0.
REQ-036 rst pulsed during GAP after D0 with sw_play held low -> outputs 10/0/0 immediately; no run until sw_play is released and pressed again.

Source files
------------

// File: rtl/melody_sequencer.sv
// melody_sequencer: plays a fixed, parameterised sequence of note codes on
// a play-switch press, with a programmable hold time per note and an
// optional silent gap after each note. A stop-switch press aborts the run.
module melody_sequencer #(
    parameter int SEQ_LEN    = 3,
    parameter int D0         = 3,
    parameter int D1         = 8,
    parameter int D2         = 6,
    parameter int D3         = 10,
    parameter int D4         = 10,
    parameter int D5         = 10,
    parameter int D6         = 10,
    parameter int D7         = 10,
    parameter int NOTE_TICKS = 12_500_000,
    parameter int GAP_TICKS  = 2_500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sw_play,
    input  logic       sw_stop,
    output logic [3:0] note,
    output logic       busy,
    output logic [2:0] step
);

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    localparam logic [3:0]  SILENCE   = 4'd10;
    localparam logic [25:0] NOTE_LAST = 26'(NOTE_TICKS - 1);
    localparam logic [25:0] GAP_LAST  = 26'(GAP_TICKS - 1);
    localparam logic [2:0]  STEP_LAST = 3'(SEQ_LEN - 1);

    // Note code lookup for a step index
    function automatic logic [3:0] note_of(input logic [2:0] idx);
        case (idx)
            3'd0:    note_of = 4'(D0);
            3'd1:    note_of = 4'(D1);
            3'd2:    note_of = 4'(D2);
            3'd3:    note_of = 4'(D3);
            3'd4:    note_of = 4'(D4);
            3'd5:    note_of = 4'(D5);
            3'd6:    note_of = 4'(D6);
            default: note_of = 4'(D7);
        endcase
    endfunction

    logic play_s1_q, play_s1_d, play_s2_q, play_s2_d, play_h_q, play_h_d;
    logic stop_s1_q, stop_s1_d, stop_s2_q, stop_s2_d, stop_h_q, stop_h_d;
    logic [1:0] valid_q, valid_d;
    logic play_arm_q, play_arm_d, stop_arm_q, stop_arm_d;
    logic play_req, stop_req;

    state_t      state_q, state_d;
    logic [3:0]  note_q, note_d;
    logic        busy_q, busy_d;
    logic [2:0]  step_q, step_d;
    logic [25:0] cnt_q, cnt_d;
    logic        advance;

    // Synchronizers, history flops and arming: a request is only accepted
    // once the synchronized switch has been seen released after reset, so a
    // switch held through reset cannot start a run.
    always_comb begin
        play_s1_d  = sw_play;
        play_s2_d  = play_s1_q;
        play_h_d   = play_s2_q;
        stop_s1_d  = sw_stop;
        stop_s2_d  = stop_s1_q;
        stop_h_d   = stop_s2_q;
        valid_d    = {valid_q[0], 1'b1};
        play_arm_d = play_arm_q | (valid_q[1] & play_s2_q);
        stop_arm_d = stop_arm_q | (valid_q[1] & stop_s2_q);
        play_req   = play_arm_q & ~play_s2_q & play_h_q;
        stop_req   = stop_arm_q & ~stop_s2_q & stop_h_q;
    end

    // Next-state logic; stop has priority over everything, including play
    always_comb begin
        state_d = state_q;
        note_d  = note_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        advance = 1'b0;
        case (state_q)
            IDLE: begin
                note_d = SILENCE;
                step_d = 3'd0;
                cnt_d  = 26'd0;
                if (play_req) begin
                    state_d = PLAY;
                    note_d  = note_of(3'd0);
                end
            end
            PLAY: begin
                if (cnt_q == NOTE_LAST) begin
                    if (GAP_TICKS > 0) begin
                        state_d = GAP;
                        note_d  = SILENCE;
                        cnt_d   = 26'd0;
                    end else begin
                        advance = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 26'd1;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    advance = 1'b1;
                end else begin
                    cnt_d = cnt_q + 26'd1;
                end
            end
            default: begin
                state_d = IDLE;
                note_d  = SILENCE;
                step_d  = 3'd0;
                cnt_d   = 26'd0;
            end
        endcase
        if (advance) begin
            cnt_d = 26'd0;
            if (step_q < STEP_LAST) begin
                state_d = PLAY;
                step_d  = step_q + 3'd1;
                note_d  = note_of(step_q + 3'd1);
            end else begin
                state_d = IDLE;
                step_d  = 3'd0;
                note_d  = SILENCE;
            end
        end
        if (stop_req) begin
            state_d = IDLE;
            note_d  = SILENCE;
            step_d  = 3'd0;
            cnt_d   = 26'd0;
        end
        busy_d = (state_d != IDLE);
    end

    // State and output registers; synchronizers reset to the released level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            play_s1_q  <= 1'b1;
            play_s2_q  <= 1'b1;
            play_h_q   <= 1'b1;
            stop_s1_q  <= 1'b1;
            stop_s2_q  <= 1'b1;
            stop_h_q   <= 1'b1;
            valid_q    <= 2'b00;
            play_arm_q <= 1'b0;
            stop_arm_q <= 1'b0;
            state_q    <= IDLE;
            note_q     <= SILENCE;
            busy_q     <= 1'b0;
            step_q     <= 3'd0;
            cnt_q      <= 26'd0;
        end else begin
            play_s1_q  <= play_s1_d;
            play_s2_q  <= play_s2_d;
            play_h_q   <= play_h_d;
            stop_s1_q  <= stop_s1_d;
            stop_s2_q  <= stop_s2_d;
            stop_h_q   <= stop_h_d;
            valid_q    <= valid_d;
            play_arm_q <= play_arm_d;
            stop_arm_q <= stop_arm_d;
            state_q    <= state_d;
            note_q     <= note_d;
            busy_q     <= busy_d;
            step_q     <= step_d;
            cnt_q      <= cnt_d;
        end
    end

    assign note = note_q;
    assign busy = busy_q;
    assign step = step_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed testbench for melody_sequencer with short note/gap timing.
// One instance uses a 2-cycle gap, the second uses no gap at all.
module tb_melody_sequencer;

    logic       clk;
    logic       rst;
    logic       sw_play;
    logic       sw_stop;
    logic       sw_play0;
    logic [3:0] note, note0;
    logic       busy, busy0;
    logic [2:0] step, step0;

    int compared   = 0;
    int mismatched = 0;
    int busy_cnt   = 0;

    melody_sequencer #(
        .SEQ_LEN(3), .D0(3), .D1(8), .D2(6),
        .NOTE_TICKS(4), .GAP_TICKS(2)
    ) dut (
        .clk(clk), .rst(rst), .sw_play(sw_play), .sw_stop(sw_stop),
        .note(note), .busy(busy), .step(step)
    );

    melody_sequencer #(
        .SEQ_LEN(3), .D0(3), .D1(8), .D2(6),
        .NOTE_TICKS(4), .GAP_TICKS(0)
    ) dut0 (
        .clk(clk), .rst(rst), .sw_play(sw_play0), .sw_stop(1'b1),
        .note(note0), .busy(busy0), .step(step0)
    );

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic play, input logic stop);
        sw_play = play;
        sw_stop = stop;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expect {note,busy,step} on the selected instance for a number of cycles
    task automatic expectHold(input string tag, input bit sel, input logic [3:0] n,
                              input logic b, input logic [2:0] s, input int cycles);
        logic [7:0] obs;
        for (int i = 0; i < cycles; i++) begin
            tick();
            obs = sel ? {note0, busy0, step0} : {note, busy, step};
            if (obs[3]) busy_cnt++;
            checkOutput(tag, {24'd0, obs}, {24'd0, n, b, s});
        end
    endtask

    // Short 2-cycle play press followed by the complete expected run
    task automatic runFull(input string tag);
        busy_cnt = 0;
        applyStimulus(1'b0, 1'b1);
        expectHold({tag, "_lat"}, 1'b0, 4'd10, 1'b0, 3'd0, 2);
        applyStimulus(1'b1, 1'b1);
        expectHold({tag, "_d0"}, 1'b0, 4'd3, 1'b1, 3'd0, 4);
        expectHold({tag, "_g0"}, 1'b0, 4'd10, 1'b1, 3'd0, 2);
        expectHold({tag, "_d1"}, 1'b0, 4'd8, 1'b1, 3'd1, 4);
        expectHold({tag, "_g1"}, 1'b0, 4'd10, 1'b1, 3'd1, 2);
        expectHold({tag, "_d2"}, 1'b0, 4'd6, 1'b1, 3'd2, 4);
        expectHold({tag, "_g2"}, 1'b0, 4'd10, 1'b1, 3'd2, 2);
        expectHold({tag, "_idle"}, 1'b0, 4'd10, 1'b0, 3'd0, 2);
        checkOutput({tag, "_busy"}, 32'(busy_cnt), 32'd18);
    endtask

    // Directed scenario sequence
    initial begin
        rst = 1'b1;
        sw_play0 = 1'b1;
        applyStimulus(1'b1, 1'b1);
        tick();
        tick();
        checkOutput("reset_out", {24'd0, note, busy, step}, {24'd0, 4'd10, 1'b0, 3'd0});
        checkOutput("reset_out0", {24'd0, note0, busy0, step0}, {24'd0, 4'd10, 1'b0, 3'd0});
        rst = 1'b0;
        expectHold("post_reset", 1'b0, 4'd10, 1'b0, 3'd0, 5);

        // Basic run with a 10-cycle play pulse
        busy_cnt = 0;
        applyStimulus(1'b0, 1'b1);
        expectHold("t1_lat", 1'b0, 4'd10, 1'b0, 3'd0, 2);
        expectHold("t1_d0", 1'b0, 4'd3, 1'b1, 3'd0, 4);
        expectHold("t1_g0", 1'b0, 4'd10, 1'b1, 3'd0, 2);
        expectHold("t1_d1", 1'b0, 4'd8, 1'b1, 3'd1, 2);
        applyStimulus(1'b1, 1'b1);
        expectHold("t1_d1b", 1'b0, 4'd8, 1'b1, 3'd1, 2);
        expectHold("t1_g1", 1'b0, 4'd10, 1'b1, 3'd1, 2);
        expectHold("t1_d2", 1'b0, 4'd6, 1'b1, 3'd2, 4);
        expectHold("t1_g2", 1'b0, 4'd10, 1'b1, 3'd2, 2);
        expectHold("t1_idle", 1'b0, 4'd10, 1'b0, 3'd0, 3);
        checkOutput("t1_busy", 32'(busy_cnt), 32'd18);

        // Zero-gap instance: notes back to back
        busy_cnt = 0;
        sw_play0 = 1'b0;
        expectHold("t2_lat", 1'b1, 4'd10, 1'b0, 3'd0, 2);
        expectHold("t2_d0", 1'b1, 4'd3, 1'b1, 3'd0, 4);
        expectHold("t2_d1", 1'b1, 4'd8, 1'b1, 3'd1, 4);
        sw_play0 = 1'b1;
        expectHold("t2_d2", 1'b1, 4'd6, 1'b1, 3'd2, 4);
        expectHold("t2_idle", 1'b1, 4'd10, 1'b0, 3'd0, 3);
        checkOutput("t2_busy", 32'(busy_cnt), 32'd12);

        // Second play press lands during D1 and is ignored; held switch never retriggers
        busy_cnt = 0;
        applyStimulus(1'b0, 1'b1);
        expectHold("t3_lat", 1'b0, 4'd10, 1'b0, 3'd0, 2);
        expectHold("t3_d0", 1'b0, 4'd3, 1'b1, 3'd0, 2);
        applyStimulus(1'b1, 1'b1);
        expectHold("t3_d0b", 1'b0, 4'd3, 1'b1, 3'd0, 2);
        expectHold("t3_g0", 1'b0, 4'd10, 1'b1, 3'd0, 2);
        applyStimulus(1'b0, 1'b1);
        expectHold("t3_d1", 1'b0, 4'd8, 1'b1, 3'd1, 4);
        expectHold("t3_g1", 1'b0, 4'd10, 1'b1, 3'd1, 2);
        expectHold("t3_d2", 1'b0, 4'd6, 1'b1, 3'd2, 4);
        expectHold("t3_g2", 1'b0, 4'd10, 1'b1, 3'd2, 2);
        expectHold("t3_idle", 1'b0, 4'd10, 1'b0, 3'd0, 4);
        checkOutput("t3_busy", 32'(busy_cnt), 32'd18);
        applyStimulus(1'b1, 1'b1);
        expectHold("t3_rel", 1'b0, 4'd10, 1'b0, 3'd0, 4);

        // Stop during D1 aborts; a later press restarts from D0
        applyStimulus(1'b0, 1'b1);
        expectHold("t4_lat", 1'b0, 4'd10, 1'b0, 3'd0, 2);
        applyStimulus(1'b1, 1'b1);
        expectHold("t4_d0", 1'b0, 4'd3, 1'b1, 3'd0, 4);
        expectHold("t4_g0", 1'b0, 4'd10, 1'b1, 3'd0, 2);
        applyStimulus(1'b1, 1'b0);
        expectHold("t4_d1", 1'b0, 4'd8, 1'b1, 3'd1, 2);
        expectHold("t4_stop", 1'b0, 4'd10, 1'b0, 3'd0, 3);
        applyStimulus(1'b1, 1'b1);
        expectHold("t4_rel", 1'b0, 4'd10, 1'b0, 3'd0, 4);
        runFull("t4_restart");

        // Play and stop pressed together in IDLE: stop wins
        applyStimulus(1'b0, 1'b0);
        expectHold("t5_both", 1'b0, 4'd10, 1'b0, 3'd0, 6);
        applyStimulus(1'b1, 1'b1);
        expectHold("t5_rel", 1'b0, 4'd10, 1'b0, 3'd0, 4);

        // Reset during the first gap with play held low
        applyStimulus(1'b0, 1'b1);
        expectHold("t6_lat", 1'b0, 4'd10, 1'b0, 3'd0, 2);
        expectHold("t6_d0", 1'b0, 4'd3, 1'b1, 3'd0, 4);
        expectHold("t6_g0", 1'b0, 4'd10, 1'b1, 3'd0, 1);
        rst = 1'b1;
        #1;
        checkOutput("t6_async", {24'd0, note, busy, step}, {24'd0, 4'd10, 1'b0, 3'd0});
        tick();
        tick();
        rst = 1'b0;
        expectHold("t6_held", 1'b0, 4'd10, 1'b0, 3'd0, 8);
        applyStimulus(1'b1, 1'b1);
        expectHold("t6_rel", 1'b0, 4'd10, 1'b0, 3'd0, 4);
        runFull("t6_repress");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
